// File: rtl/fetch_pkg.sv
// +----------------------------------------------------------------------+
// | fetch_pkg: constants and width helpers shared by fetch/decode. rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0,x0,0

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue_ram.sv
// +----------------------------------------------------------------------+
// | fetch_queue_ram: 1W/1R entry array, sync write, comb read. rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 52,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/fetch_queue_unit.sv
// +----------------------------------------------------------------------+
// | fetch_queue_unit: fetch-to-decode FIFO with flush and NOP on empty.   |
// | Optional FETCH_QUEUE_BYPASS_EN: empty-queue 0-cycle pass-through. 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDRESS_BITS = 20,
  parameter int                    DEPTH        = 4,
  parameter logic [DATA_WIDTH-1:0] NOP          = NOP_INSTR[DATA_WIDTH-1:0]
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic [DATA_WIDTH-1:0]         instruction_fetch,
  input  logic [ADDRESS_BITS-1:0]       inst_PC_fetch,
  input  logic                          decode_ready,
  output logic                          decode_valid,
  output logic [DATA_WIDTH-1:0]         instruction_decode,
  output logic [ADDRESS_BITS-1:0]       inst_PC_decode,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int             PW         = ptr_width(DEPTH);
  localparam int             CW         = count_width(DEPTH);
  localparam int             EW         = DATA_WIDTH + ADDRESS_BITS;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0]  PTR_ONE    = PW'(1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [ADDRESS_BITS-1:0] last_pc_q, last_pc_d;

  logic          head_valid;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [EW-1:0] head_entry;

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .PTR_W (PW)
  ) u_ram (
    .clk     (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data ({inst_PC_fetch, instruction_fetch}),
    .rd_addr (rd_ptr_q),
    .rd_data (head_entry)
  );

  always_comb begin
    head_valid         = (count_q != '0);
    fetch_ready        = (count_q != FULL_COUNT) & ~reset;
    bypass             = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass             = ~head_valid & fetch_valid & fetch_ready & ~flush;
`endif
    decode_valid       = (head_valid | bypass) & ~flush;
    instruction_decode = NOP;
    inst_PC_decode     = last_pc_q;
    if (bypass) begin
      instruction_decode = instruction_fetch;
      inst_PC_decode     = inst_PC_fetch;
    end else if (decode_valid) begin
      instruction_decode = head_entry[DATA_WIDTH-1:0];
      inst_PC_decode     = head_entry[EW-1:DATA_WIDTH];
    end

    // A bypassed entry consumed by decode in the same cycle is never stored.
    pop  = head_valid & decode_ready & ~flush;
    push = fetch_valid & fetch_ready & ~flush & ~(bypass & decode_ready);

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_pc_d = inst_PC_decode;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
// +----------------------------------------------------------------------+
// | tb_fetch_queue_unit: directed + random stimulus vs queue model. 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_queue_unit;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] NOP_EXP = 32'h00000013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] instruction_fetch;
  logic [19:0] inst_PC_fetch;
  logic        decode_ready;
  logic        decode_valid;
  logic [31:0] instruction_decode;
  logic [19:0] inst_PC_decode;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  logic [51:0] model_q[$];
  logic [19:0] model_last_pc;

  fetch_queue_unit dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .fetch_valid        (fetch_valid),
    .fetch_ready        (fetch_ready),
    .instruction_fetch  (instruction_fetch),
    .inst_PC_fetch      (inst_PC_fetch),
    .decode_ready       (decode_ready),
    .decode_valid       (decode_valid),
    .instruction_decode (instruction_decode),
    .inst_PC_decode     (inst_PC_decode),
    .count              (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs, then advance the model across the next posedge.
  task automatic step(input logic fv, input logic [19:0] pc, input logic [31:0] ins,
                      input logic dr, input logic fl);
    logic        exp_valid;
    logic [31:0] exp_ins;
    logic [19:0] exp_pc;
    logic        exp_ready;
    logic        byp;
    @(negedge clock);
    fetch_valid       = fv;
    inst_PC_fetch     = pc;
    instruction_fetch = ins;
    decode_ready      = dr;
    flush             = fl;
    #1;
    exp_ready = (model_q.size() < DEPTH);
    byp       = BYPASS && (model_q.size() == 0) && fv && !fl;
    exp_valid = 1'b0;
    exp_ins   = NOP_EXP;
    exp_pc    = model_last_pc;
    if (!fl && model_q.size() > 0) begin
      exp_valid = 1'b1;
      exp_ins   = model_q[0][31:0];
      exp_pc    = model_q[0][51:32];
    end else if (byp) begin
      exp_valid = 1'b1;
      exp_ins   = ins;
      exp_pc    = pc;
    end
    check("decode_valid", {31'd0, decode_valid}, {31'd0, exp_valid});
    check("instruction_decode", instruction_decode, exp_ins);
    check("inst_PC_decode", {12'd0, inst_PC_decode}, {12'd0, exp_pc});
    check("count", {29'd0, count}, model_q.size());
    check("fetch_ready", {31'd0, fetch_ready}, {31'd0, exp_ready});
    model_last_pc = exp_pc;
    if (fl) begin
      model_q.delete();
    end else begin
      if (byp && dr) begin
        // consumed straight from the fetch side
      end else begin
        if (dr && model_q.size() > 0) void'(model_q.pop_front());
        if (fv && exp_ready) model_q.push_back({pc, ins});
      end
    end
  endtask

  task automatic idle_inputs();
    fetch_valid       = 1'b0;
    flush             = 1'b0;
    decode_ready      = 1'b0;
    inst_PC_fetch     = '0;
    instruction_fetch = '0;
  endtask

  initial begin
    logic [19:0] pc;
    idle_inputs();
    reset = 1'b1;
    model_last_pc = '0;
    #12;
    check("rst_valid", {31'd0, decode_valid}, 32'd0);
    check("rst_instr", instruction_decode, NOP_EXP);
    check("rst_pc", {12'd0, inst_PC_decode}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_ready", {31'd0, fetch_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    step(1'b0, 20'h0, 32'h0, 1'b0, 1'b0);

    // Fill to DEPTH, refuse a fifth entry, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 20'(i * 4), 32'hA000_0000 + i, 1'b0, 1'b0);
    step(1'b1, 20'h10, 32'hA000_0010, 1'b0, 1'b0);
    step(1'b1, 20'h10, 32'hA000_0010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 20'h0, 32'h0, 1'b1, 1'b0);

    // Steady push+pop at count=2 with pointer wrap.
    step(1'b1, 20'h200, 32'hB000_0000, 1'b0, 1'b0);
    step(1'b1, 20'h204, 32'hB000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 20'h208 + 20'(i * 4), 32'hB000_0002 + i, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 20'h0, 32'h0, 1'b1, 1'b0);

    // Flush at count=3 together with a push of 0x40.
    for (int i = 0; i < 3; i++) step(1'b1, 20'h300 + 20'(i * 4), 32'hC000_0000 + i, 1'b0, 1'b0);
    step(1'b1, 20'h40, 32'hC000_0040, 1'b0, 1'b1);
    step(1'b1, 20'h80, 32'hC000_0080, 1'b0, 1'b0);
    step(1'b0, 20'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 20'h0, 32'h0, 1'b1, 1'b0);

    // Flush while full: ready again the next cycle.
    for (int i = 0; i < 4; i++) step(1'b1, 20'h400 + 20'(i * 4), 32'hD000_0000 + i, 1'b0, 1'b0);
    step(1'b0, 20'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 20'h0, 32'h0, 1'b0, 1'b0);

    // Empty queue, push 0x100 with decode ready (bypass-sensitive).
    step(1'b1, 20'h100, 32'hE000_0100, 1'b1, 1'b0);
    step(1'b0, 20'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 20'h0, 32'h0, 1'b1, 1'b0);

    // Reset asserted mid-drain at count=2.
    for (int i = 0; i < 3; i++) step(1'b1, 20'h500 + 20'(i * 4), 32'hF000_0000 + i, 1'b0, 1'b0);
    step(1'b0, 20'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    check("pre_rst_count", {29'd0, count}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, decode_valid}, 32'd0);
    check("mid_rst_instr", instruction_decode, NOP_EXP);
    check("mid_rst_pc", {12'd0, inst_PC_decode}, 32'd0);
    check("mid_rst_count", {29'd0, count}, 32'd0);
    model_q.delete();
    model_last_pc = '0;
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;

    // Random traffic.
    pc = 20'h1000;
    for (int i = 0; i < 600; i++) begin
      logic fv, dr, fl;
      fv = ($urandom_range(0, 99) < 60);
      dr = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) < 5);
      step(fv, pc, $urandom, dr, fl);
      pc = pc + 20'd4;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
